dcache_ctrl: RTL

Direct-mapped, write-back data cache controller that serves the CPU's byte load/store port and produces the `BUSYWAIT` stall consumed by the register file and PC logic. It sits between the CPU datapath and the 32-bit-block main data memory. Hits complete without stalling. Misses run a write-back/fetch sequence against main memory while `BUSYWAIT` is held high.

---
 rtl/dcache_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller for the CPU byte load/store port (8 lines x 4 bytes).
// Latency: hits complete in the request cycle; clean miss stalls 1+N_fetch, dirty miss 1+N_wb+N_fetch.
// Backpressure: BUSYWAIT stalls the CPU during misses; MEM_BUSYWAIT holds WRITEBACK/FETCH until completion.
//
// Ports: CLK, RESET (sync, active-low); CPU side READ/WRITE/ADDRESS/WRITEDATA -> READDATA/BUSYWAIT;
//        memory side MEM_READ/MEM_WRITE/MEM_ADDRESS/MEM_WRITEDATA <- MEM_READDATA/MEM_BUSYWAIT.
// Optional build macro DCACHE_STATS_EN adds saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FETCH     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] data_q  [8];
    logic [31:0] data_d  [8];
    logic [2:0]  tag_q   [8];
    logic [2:0]  tag_d   [8];
    logic [7:0]  valid_q, valid_d;
    logic [7:0]  dirty_q, dirty_d;

    logic [2:0]  req_tag;
    logic [2:0]  req_idx;
    logic [1:0]  req_off;
    logic        req;
    logic        hit;

    assign req_tag = ADDRESS[7:5];
    assign req_idx = ADDRESS[4:2];
    assign req_off = ADDRESS[1:0];
    assign req     = READ | WRITE;
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Read path is purely combinational so a hit costs no stall cycle.
    assign READDATA = data_q[req_idx][{req_off, 3'b000} +: 8];

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        tag_d         = tag_q;
        valid_d       = valid_q;
        dirty_d       = dirty_q;
        BUSYWAIT      = 1'b0;
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = ADDRESS[7:2];
        MEM_WRITEDATA = data_q[req_idx];

        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    BUSYWAIT = 1'b1;
                    // dirty is only ever set on a valid line, but keep both for clarity
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else if (WRITE && hit) begin
                    data_d[req_idx][{req_off, 3'b000} +: 8] = WRITEDATA;
                    dirty_d[req_idx] = 1'b1;
                end
            end
            S_WRITEBACK: begin
                BUSYWAIT    = 1'b1;
                MEM_WRITE   = 1'b1;
                MEM_ADDRESS = {tag_q[req_idx], req_idx};
                if (!MEM_BUSYWAIT) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                BUSYWAIT = 1'b1;
                MEM_READ = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    data_d[req_idx]  = MEM_READDATA;
                    tag_d[req_idx]   = req_tag;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset aborts any transaction: the arrays keep their old contents
        // (no partial fill or store) and the CPU/memory strobes drop at once.
        if (!RESET) begin
            state_d   = S_IDLE;
            data_d    = data_q;
            tag_d     = tag_q;
            valid_d   = '0;
            dirty_d   = '0;
            BUSYWAIT  = 1'b0;
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        state_q <= state_d;
        valid_q <= valid_d;
        dirty_q <= dirty_d;
        data_q  <= data_d;
        tag_q   <= tag_d;
    end

`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        just_filled_q, just_filled_d;
    logic        fill_done;
    logic        miss_start;
    logic        hit_done;

    assign fill_done  = (state_q == S_FETCH) && !MEM_BUSYWAIT;
    assign miss_start = (state_q == S_IDLE) && req && !hit;
    assign hit_done   = (state_q == S_IDLE) && req && hit;

    always_comb begin
        just_filled_d = fill_done;
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        // The hit that retires a miss right after its fill is not a real hit.
        if (hit_done && !just_filled_q && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (miss_start && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            just_filled_q <= 1'b0;
        end else begin
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
            just_filled_q <= just_filled_d;
        end
    end

    assign HIT_COUNT  = hit_cnt_q;
    assign MISS_COUNT = miss_cnt_q;
`endif

endmodule
